wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/wb_load_align.sv | 44 ++++
 rtl/wb_stage.sv | 105 ++++++++++
 tb/tb_wb_stage.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file addressing, bus widths, sentinel
// values and the load func3 encodings used by the writeback stage.
package cpu_pkg;

  localparam int unsigned RegBusWidth   = 32;
  localparam int unsigned RegAddrWidth  = 5;
  localparam int unsigned Func3BusWidth = 3;
  localparam int unsigned InstretWidth  = 64;

  typedef logic [RegAddrWidth-1:0] reg_addr_t;

  localparam reg_addr_t                ZERO_REG     = '0;
  localparam logic [RegBusWidth-1:0]   ZeroWord     = '0;
  localparam logic                     WriteDisable = 1'b0;
  localparam logic                     NotMem2Reg   = 1'b0;

  // Load func3 encodings; any other value returns the full word.
  localparam logic [Func3BusWidth-1:0] F3_LB  = 3'b000;
  localparam logic [Func3BusWidth-1:0] F3_LH  = 3'b001;
  localparam logic [Func3BusWidth-1:0] F3_LW  = 3'b010;
  localparam logic [Func3BusWidth-1:0] F3_LBU = 3'b100;
  localparam logic [Func3BusWidth-1:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_load_align.sv
// Load-data aligner: selects the byte/halfword lane of a data-memory word
// and sign- or zero-extends it according to the load func3.
//   dm_rdata : raw 32-bit word read from data memory
//   func3    : load type
//   offset   : low two bits of the effective address
//   data     : aligned, extended load result
module wb_load_align
  import cpu_pkg::*;
(
  input  logic [RegBusWidth-1:0]   dm_rdata,
  input  logic [Func3BusWidth-1:0] func3,
  input  logic [1:0]               offset,
  output logic [RegBusWidth-1:0]   data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane selection; offset[0] is ignored for halfwords.
  always_comb begin
    byte_lane = dm_rdata[7:0];
    case (offset)
      2'd0:    byte_lane = dm_rdata[7:0];
      2'd1:    byte_lane = dm_rdata[15:8];
      2'd2:    byte_lane = dm_rdata[23:16];
      default: byte_lane = dm_rdata[31:24];
    endcase
    half_lane = offset[1] ? dm_rdata[31:16] : dm_rdata[15:0];
  end

  // Extension by load type.
  always_comb begin
    data = dm_rdata;
    case (func3)
      F3_LB:   data = {{24{byte_lane[7]}}, byte_lane};
      F3_LH:   data = {{16{half_lane[15]}}, half_lane};
      F3_LBU:  data = {24'd0, byte_lane};
      F3_LHU:  data = {16'd0, half_lane};
      F3_LW:   data = dm_rdata;
      default: data = dm_rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: selects the writeback value, owns the integer register
// file (x0 hardwired zero, two combinational read ports with write-through
// bypass) and counts retired instructions.
//   clk, rstn            : clock, asynchronous active-low reset
//   wb_*                 : retiring instruction (wb_pc == 0 marks a bubble)
//   dm_rdata             : data-memory word for a load in WB
//   rs1/rs2_addr, _data  : ID-stage register reads
//   wb_wdata, wb_we      : final writeback value and qualified write strobe
//   instret              : 64-bit retired-instruction counter
module wb_stage
  import cpu_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  reg_addr_t                wb_rd,
  input  logic                     wb_wreg,
  input  logic                     wb_mem2reg,
  input  logic [RegBusWidth-1:0]   wb_from_alu,
  input  logic [Func3BusWidth-1:0] wb_func3,
  input  logic [RegBusWidth-1:0]   wb_pc,
  input  logic [RegBusWidth-1:0]   dm_rdata,
  input  reg_addr_t                rs1_addr,
  input  reg_addr_t                rs2_addr,
  output logic [RegBusWidth-1:0]   rs1_data,
  output logic [RegBusWidth-1:0]   rs2_data,
  output logic [RegBusWidth-1:0]   wb_wdata,
  output logic                     wb_we,
  output logic [InstretWidth-1:0]  instret
);

  logic [RegBusWidth-1:0]  load_data;
  logic [RegBusWidth-1:0]  regs_q [NUM_REGS];
  logic [RegBusWidth-1:0]  regs_d [NUM_REGS];
  logic [InstretWidth-1:0] instret_q;
  logic [InstretWidth-1:0] instret_d;

  function automatic logic in_range(input reg_addr_t a);
    return 32'(a) < NUM_REGS;
  endfunction

  wb_load_align u_load_align (
    .dm_rdata (dm_rdata),
    .func3    (wb_func3),
    .offset   (wb_from_alu[1:0]),
    .data     (load_data)
  );

  // Writeback value and qualified strobe.
  assign wb_wdata = (wb_mem2reg != NotMem2Reg) ? load_data : wb_from_alu;
  assign wb_we    = (wb_wreg != WriteDisable) && (wb_rd != ZERO_REG);

  // Register file next state; entry 0 is never written.
  always_comb begin
    regs_d = regs_q;
    if (wb_we && in_range(wb_rd)) begin
      regs_d[wb_rd] = wb_wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= ZeroWord;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports with same-cycle bypass of the write in WB.
  always_comb begin
    rs1_data = ZeroWord;
    if (rs1_addr != ZERO_REG && in_range(rs1_addr)) begin
      rs1_data = (wb_we && rs1_addr == wb_rd) ? wb_wdata : regs_q[rs1_addr];
    end
  end

  always_comb begin
    rs2_data = ZeroWord;
    if (rs2_addr != ZERO_REG && in_range(rs2_addr)) begin
      rs2_data = (wb_we && rs2_addr == wb_rd) ? wb_wdata : regs_q[rs2_addr];
    end
  end

  // Retire counter: any non-bubble PC retires; wraps silently.
  always_comb begin
    instret_d = instret_q;
    if (wb_pc != ZeroWord) begin
      instret_d = instret_q + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: load-alignment vector table, directed
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_wb_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  reg_addr_t   wb_rd, rs1_addr, rs2_addr;
  logic        wb_wreg, wb_mem2reg;
  logic [31:0] wb_from_alu, wb_pc, dm_rdata;
  logic [2:0]  wb_func3;
  logic [31:0] rs1_data, rs2_data, wb_wdata;
  logic        wb_we;
  logic [63:0] instret;

  always #5 clk = ~clk;

  wb_stage #(.NUM_REGS(32)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .wb_rd       (wb_rd),
    .wb_wreg     (wb_wreg),
    .wb_mem2reg  (wb_mem2reg),
    .wb_from_alu (wb_from_alu),
    .wb_func3    (wb_func3),
    .wb_pc       (wb_pc),
    .dm_rdata    (dm_rdata),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .wb_wdata    (wb_wdata),
    .wb_we       (wb_we),
    .instret     (instret)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle();
    wb_rd = '0; wb_wreg = 1'b0; wb_mem2reg = 1'b0; wb_from_alu = '0;
    wb_func3 = '0; wb_pc = '0; dm_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Reference load extraction: shift the lane down, then extend.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [31:0] b, h;
    b = w >> (8 * int'(off));
    h = w >> (16 * int'(off[1]));
    case (f3)
      3'b000:  return 32'($signed(b[7:0]));
      3'b001:  return 32'($signed(h[15:0]));
      3'b100:  return {24'd0, b[7:0]};
      3'b101:  return {16'd0, h[15:0]};
      default: return w;
    endcase
  endfunction

  typedef struct {
    logic [31:0] rdata;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic        m2r;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  logic [31:0] mregs [32];
  logic [63:0] minst;

  initial begin
    vec_t v;
    logic [31:0] exp_w, exp1, exp2;
    logic        exp_we;

    vecs.push_back('{32'h8070_6050, 3'b000, 2'd3, 1'b1, 32'hFFFF_FF80});
    vecs.push_back('{32'h8070_6050, 3'b100, 2'd3, 1'b1, 32'h0000_0080});
    vecs.push_back('{32'h8001_7FFF, 3'b001, 2'd2, 1'b1, 32'hFFFF_8001});
    vecs.push_back('{32'h8001_7FFF, 3'b001, 2'd0, 1'b1, 32'h0000_7FFF});
    vecs.push_back('{32'h8001_7FFF, 3'b001, 2'd1, 1'b1, 32'h0000_7FFF});
    vecs.push_back('{32'h8001_7FFF, 3'b101, 2'd3, 1'b1, 32'h0000_8001});
    vecs.push_back('{32'h8070_6050, 3'b000, 2'd0, 1'b1, 32'h0000_0050});
    vecs.push_back('{32'h8070_6050, 3'b000, 2'd1, 1'b1, 32'h0000_0060});
    vecs.push_back('{32'h8070_6050, 3'b100, 2'd2, 1'b1, 32'h0000_0070});
    vecs.push_back('{32'h8070_6050, 3'b010, 2'd2, 1'b1, 32'h8070_6050});
    vecs.push_back('{32'h8070_6050, 3'b011, 2'd1, 1'b1, 32'h8070_6050});
    vecs.push_back('{32'h8070_6050, 3'b110, 2'd3, 1'b1, 32'h8070_6050});
    vecs.push_back('{32'h8070_6050, 3'b111, 2'd0, 1'b1, 32'h8070_6050});
    vecs.push_back('{32'h8070_6050, 3'b000, 2'd3, 1'b0, 32'h1234_5673});

    rstn = 1'b1;
    idle();
    rs1_addr = '0; rs2_addr = '0;
    do_reset();

    // Reset state.
    #1;
    check("reset_instret", instret, 64'd0);
    for (int r = 1; r < 32; r++) begin
      rs1_addr = reg_addr_t'(r);
      #1;
      check($sformatf("reset_x%0d", r), 64'(rs1_data), 64'd0);
    end

    // Load alignment / writeback mux table.
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge clk);
      idle();
      dm_rdata    = v.rdata;
      wb_func3    = v.f3;
      wb_mem2reg  = v.m2r;
      wb_from_alu = 32'h1234_5670 | 32'(v.off);
      #1;
      check($sformatf("vec%0d_wdata", i), 64'(wb_wdata), 64'(v.exp));
      check($sformatf("vec%0d_we", i), 64'(wb_we), 64'd0);
    end

    // Write x5 with same-cycle bypass, then read from the array.
    @(negedge clk);
    idle();
    wb_rd = 5'd5; wb_wreg = 1'b1; wb_from_alu = 32'h1234_5678; wb_pc = 32'h100;
    rs1_addr = 5'd5; rs2_addr = 5'd5;
    #1;
    check("bypass_we", 64'(wb_we), 64'd1);
    check("bypass_rs1", 64'(rs1_data), 64'h1234_5678);
    check("bypass_rs2", 64'(rs2_data), 64'h1234_5678);
    @(negedge clk);
    idle();
    #1;
    check("array_rs1", 64'(rs1_data), 64'h1234_5678);
    check("array_rs2", 64'(rs2_data), 64'h1234_5678);

    // x0 write is suppressed.
    wb_rd = 5'd0; wb_wreg = 1'b1; wb_from_alu = 32'hDEAD_BEEF; rs2_addr = 5'd0;
    #1;
    check("x0_we", 64'(wb_we), 64'd0);
    check("x0_rs2", 64'(rs2_data), 64'd0);
    @(negedge clk);
    idle();
    #1;
    check("x0_after", 64'(rs2_data), 64'd0);

    // Three retires, two bubbles, then an asynchronous reset mid-cycle.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      idle();
      wb_pc = 32'h1000 + 32'(4 * k);
      if (k == 0) begin
        wb_rd = 5'd5; wb_wreg = 1'b1; wb_from_alu = 32'hAAAA_0005;
      end
    end
    repeat (2) begin
      @(negedge clk);
      idle();
    end
    rs1_addr = 5'd5;
    #1;
    check("instret_3", instret, 64'd3);
    check("x5_before_rst", 64'(rs1_data), 64'hAAAA_0005);
    #2 rstn = 1'b0;
    #1;
    check("instret_async_rst", instret, 64'd0);
    check("x5_async_rst", 64'(rs1_data), 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Reset held across an edge discards the in-flight write.
    @(negedge clk);
    wb_rd = 5'd7; wb_wreg = 1'b1; wb_from_alu = 32'h0000_0077; wb_pc = 32'h300;
    #2 rstn = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rstn = 1'b1;
    idle();
    rs1_addr = 5'd7;
    #1;
    check("rst_discard_x7", 64'(rs1_data), 64'd0);
    check("rst_discard_instret", instret, 64'd0);

    // instret wrap from all-ones to zero.
    @(negedge clk);
    idle();
    force dut.instret_d = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.instret_d;
    check("instret_max", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    wb_pc = 32'h400;
    @(posedge clk);
    #1;
    check("instret_wrap", instret, 64'd0);

    // Randomized run against the behavioural model.
    do_reset();
    for (int r = 0; r < 32; r++) mregs[r] = '0;
    minst = '0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        idle();
      end else begin
        wb_rd       = reg_addr_t'($urandom_range(0, 1) != 0 ? $urandom_range(0, 7) : $urandom_range(0, 31));
        wb_wreg     = 1'($urandom_range(0, 1));
        wb_mem2reg  = 1'($urandom_range(0, 1));
        wb_from_alu = $urandom;
        wb_func3    = 3'($urandom_range(0, 7));
        wb_pc       = $urandom | 32'h4;
        dm_rdata    = $urandom;
      end
      rs1_addr = reg_addr_t'($urandom_range(0, 7));
      rs2_addr = reg_addr_t'($urandom_range(0, 1) != 0 ? $urandom_range(0, 7) : $urandom_range(0, 31));
      #1;
      exp_w  = wb_mem2reg ? ref_load(dm_rdata, wb_func3, wb_from_alu[1:0]) : wb_from_alu;
      exp_we = wb_wreg && (wb_rd != 5'd0);
      exp1   = (rs1_addr == 5'd0) ? 32'd0 : (exp_we && rs1_addr == wb_rd) ? exp_w : mregs[rs1_addr];
      exp2   = (rs2_addr == 5'd0) ? 32'd0 : (exp_we && rs2_addr == wb_rd) ? exp_w : mregs[rs2_addr];
      check("rnd_wdata", 64'(wb_wdata), 64'(exp_w));
      check("rnd_we", 64'(wb_we), 64'(exp_we));
      check("rnd_rs1", 64'(rs1_data), 64'(exp1));
      check("rnd_rs2", 64'(rs2_data), 64'(exp2));
      @(posedge clk);
      if (exp_we) mregs[wb_rd] = exp_w;
      if (wb_pc != 32'd0) minst = minst + 64'd1;
      #1;
      check("rnd_instret", instret, minst);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
